coco_ioctl_upload: RTL and testbench
====================================

Name: coco_ioctl_upload

Overview:
- Core-side responder for the HPS ioctl upload direction, the counterpart of the cartridge download path.
- hps_io pulses a read strobe with an address. This block fetches the byte from core memory through a variable-latency request/acknowledge port, presents it on ioctl_din, and stalls hps_io with ioctl_wait while the fetch is in flight.
- It also keeps a running byte count and an additive checksum for the debug overlay.

Parameters:
- ADDR_W, 16, width of ioctl_addr and mem_addr.
- BASE_ADDR, 16'h0000, core memory address that corresponds to ioctl_addr 0.
- UPLOAD_LEN, 16'h8000, number of bytes in one image; reads at or beyond this return 8'hFF with no memory access.
- TIMEOUT, 255, maximum cycles to wait for mem_ack before the fetch is abandoned (8-bit counter).

Ports:
- clk_sys  in  1  system clock (57.272 MHz).
- reset  in  1  asynchronous, active-high reset.
- ioctl_upload  in  1  high for the whole upload session.
- ioctl_rd  in  1  one-cycle read strobe from hps_io.
- ioctl_addr  in  ADDR_W  byte address of the requested byte, valid with ioctl_rd.
- ioctl_din  out  8  byte returned to hps_io.
- ioctl_wait  out  1  high while the requested byte is not yet valid.
- mem_req  out  1  memory read request; held until acknowledged.
- mem_addr  out  ADDR_W  equals BASE_ADDR + ioctl_addr, modulo 2^ADDR_W.
- mem_ack  in  1  one-cycle pulse; mem_dout is valid in the same cycle.
- mem_dout  in  8  memory read data.
- byte_count  out  ADDR_W  number of bytes delivered in this session.
- checksum  out  8  sum modulo 256 of all delivered bytes.
- timeout_err  out  1  sticky; set when any fetch in the session timed out.
- done  out  1  one-cycle pulse on the falling edge of ioctl_upload.

Behaviour:
- Reset values: ioctl_din=0, ioctl_wait=0, mem_req=0, mem_addr=0, byte_count=0, checksum=0, timeout_err=0, done=0. The FSM returns to IDLE, and a fetch in flight is abandoned. A mem_ack arriving after reset is ignored.
- FSM states: IDLE, REQ, DELIVER.
- IDLE:
  - ioctl_rd=1 with ioctl_upload=1 and ioctl_addr < UPLOAD_LEN: latch the address, drive mem_addr, set mem_req=1 and ioctl_wait=1, clear the timeout counter, go to REQ. Both signals are registered, so they rise the cycle after the strobe.
  - ioctl_rd=1 with ioctl_addr >= UPLOAD_LEN: ioctl_din<=8'hFF and ioctl_wait stays 0. No memory access and no count or checksum update.
  - ioctl_rd while ioctl_upload=0 is ignored.
- REQ:
  - On mem_ack: ioctl_din<=mem_dout, mem_req<=0, go to DELIVER.
  - If the counter reaches TIMEOUT before mem_ack: ioctl_din<=8'hFF, mem_req<=0, timeout_err<=1, go to DELIVER.
  - mem_ack in the same cycle the counter reaches TIMEOUT: the ack wins and timeout_err is not set.
- DELIVER: for exactly one cycle, ioctl_wait<=0, byte_count+=1, checksum+=ioctl_din (8-bit wrap), then go to IDLE. A timed-out byte (FF) is still counted and summed.
- Latency: with mem_ack arriving k cycles after mem_req rises, ioctl_din is valid and ioctl_wait falls k+2 cycles after the ioctl_rd strobe.
- ioctl_rd strobes outside IDLE are ignored; hps_io does not issue them while ioctl_wait=1.
- mem_ack outside REQ is ignored.
- Session start (ioctl_upload rising edge): clear byte_count, checksum and timeout_err.
- Session end (ioctl_upload falling edge):
  - done=1 for one cycle.
  - byte_count and checksum hold until the next session start.
  - A fetch in progress still completes, but its byte is not counted.
- mem_addr wraps modulo 2^ADDR_W; no overflow flag.
- byte_count saturates at all-ones.

Test Plan:
- Reset mid-fetch: assert reset while in REQ -> all outputs 0 in the same cycle; a later mem_ack pulse causes no ioctl_din change.
- Normal read:
  - Stimulus: upload=1, ioctl_rd at addr 16'h0005, BASE_ADDR=16'hC000, mem_ack 3 cycles after mem_req with mem_dout=8'h5A.
  - Required: mem_addr=16'hC005; ioctl_din=8'h5A and ioctl_wait falls 5 cycles after the strobe; byte_count=1; checksum=8'h5A.
- Checksum wrap: deliver bytes 8'hF0, 8'h20, 8'h01 -> checksum=8'h11, byte_count=3.
- Timeout:
  - Stimulus: mem_ack never asserted.
  - Required: ioctl_din=8'hFF after 255 cycles in REQ; timeout_err=1, sticky across later good reads; cleared on the next session start.
- Out of range: ioctl_rd at addr 16'h8000 with UPLOAD_LEN=16'h8000 -> mem_req stays 0, ioctl_din=8'hFF, ioctl_wait stays 0, byte_count unchanged.
- Session end mid-fetch: drop ioctl_upload while in REQ -> done pulses for 1 cycle; the ack still clears mem_req; byte_count is not incremented.

Source files
------------

// File: rtl/coco_ioctl_upload.sv
// Core-side responder for hps_io ioctl uploads: fetches bytes through a
// request/acknowledge memory port and tracks byte count and checksum.
module coco_ioctl_upload #(
   parameter int unsigned        ADDR_W     = 16,
   parameter logic [ADDR_W-1:0]  BASE_ADDR  = 16'h0000,
   parameter logic [ADDR_W-1:0]  UPLOAD_LEN = 16'h8000,
   parameter int unsigned        TIMEOUT    = 255
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ioctl_upload,
   input  logic              ioctl_rd,
   input  logic [ADDR_W-1:0] ioctl_addr,
   output logic [7:0]        ioctl_din,
   output logic              ioctl_wait,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] byte_count,
   output logic [7:0]        checksum,
   output logic              timeout_err,
   output logic              done
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] REQ     = 2'd1;
   localparam logic [1:0] DELIVER = 2'd2;

   // Last counter value before the fetch is abandoned on the following edge.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   logic [1:0] state;
   logic [7:0] tcnt;
   logic       upload_q;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         tcnt        <= '0;
         upload_q    <= 1'b0;
         ioctl_din   <= '0;
         ioctl_wait  <= 1'b0;
         mem_req     <= 1'b0;
         mem_addr    <= '0;
         byte_count  <= '0;
         checksum    <= '0;
         timeout_err <= 1'b0;
         done        <= 1'b0;
      end else begin
         upload_q <= ioctl_upload;
         done     <= upload_q & ~ioctl_upload;

         case (state)
            IDLE: begin
               if (ioctl_rd && ioctl_upload) begin
                  if (ioctl_addr < UPLOAD_LEN) begin
                     mem_addr   <= BASE_ADDR + ioctl_addr;
                     mem_req    <= 1'b1;
                     ioctl_wait <= 1'b1;
                     tcnt       <= '0;
                     state      <= REQ;
                  end else begin
                     ioctl_din <= 8'hFF;
                  end
               end
            end
            REQ: begin
               // An ack on the final timeout cycle still wins.
               if (mem_ack) begin
                  ioctl_din <= mem_dout;
                  mem_req   <= 1'b0;
                  state     <= DELIVER;
               end else if (tcnt == TMO_LAST) begin
                  ioctl_din   <= 8'hFF;
                  mem_req     <= 1'b0;
                  timeout_err <= 1'b1;
                  state       <= DELIVER;
               end else begin
                  tcnt <= tcnt + 8'd1;
               end
            end
            DELIVER: begin
               ioctl_wait <= 1'b0;
               state      <= IDLE;
               if (ioctl_upload) begin
                  if (byte_count != '1)
                     byte_count <= byte_count + 1'b1;
                  checksum <= checksum + ioctl_din;
               end
            end
            default: state <= IDLE;
         endcase

         // Session start takes priority over any update in the same cycle.
         if (ioctl_upload && !upload_q) begin
            byte_count  <= '0;
            checksum    <= '0;
            timeout_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_coco_ioctl_upload.sv
// Directed bench for coco_ioctl_upload: table of reads plus hand sequences
// for reset, timeout, ack/timeout race and session end mid-fetch.
module tb_coco_ioctl_upload;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        ioctl_upload;
   logic        ioctl_rd;
   logic [15:0] ioctl_addr;
   logic [7:0]  ioctl_din;
   logic        ioctl_wait;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [7:0]  mem_dout;
   logic [15:0] byte_count;
   logic [7:0]  checksum;
   logic        timeout_err;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_sys = ~clk_sys;

   coco_ioctl_upload #(
      .ADDR_W     (16),
      .BASE_ADDR  (16'hC000),
      .UPLOAD_LEN (16'h8000),
      .TIMEOUT    (255)
   ) dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .ioctl_upload (ioctl_upload),
      .ioctl_rd     (ioctl_rd),
      .ioctl_addr   (ioctl_addr),
      .ioctl_din    (ioctl_din),
      .ioctl_wait   (ioctl_wait),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_ack      (mem_ack),
      .mem_dout     (mem_dout),
      .byte_count   (byte_count),
      .checksum     (checksum),
      .timeout_err  (timeout_err),
      .done         (done)
   );

   typedef struct {
      logic        new_sess;
      logic [15:0] addr;
      logic [7:0]  dout;
      int          k;
      logic        oor;
      logic [15:0] exp_maddr;
      logic [7:0]  exp_din;
      logic [15:0] exp_bc;
      logic [7:0]  exp_cs;
      logic        exp_terr;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic new_session();
      @(posedge clk_sys); #1 ioctl_upload = 1'b0;
      @(posedge clk_sys);
      @(negedge clk_sys) chk("done_pulse", done, 1'b1);
      @(posedge clk_sys);
      @(negedge clk_sys) chk("done_clear", done, 1'b0);
      @(posedge clk_sys); #1 ioctl_upload = 1'b1;
      @(posedge clk_sys);
      @(negedge clk_sys);
      chk("sess_bc", byte_count, 16'h0);
      chk("sess_cs", checksum, 8'h00);
      chk("sess_terr", timeout_err, 1'b0);
   endtask

   // Strobe at E0, sampled E1; ack sampled at E(1+k); wait low after E(k+2).
   task automatic do_read(input vec_t v);
      @(posedge clk_sys); #1 ioctl_rd = 1'b1; ioctl_addr = v.addr;
      @(posedge clk_sys); #1 ioctl_rd = 1'b0;
      if (v.oor) begin
         @(negedge clk_sys);
         chk("oor_req", mem_req, 1'b0);
         chk("oor_wait", ioctl_wait, 1'b0);
         chk("oor_din", ioctl_din, v.exp_din);
         chk("oor_maddr", mem_addr, v.exp_maddr);
         @(negedge clk_sys);
         @(negedge clk_sys);
         chk("oor_req_late", mem_req, 1'b0);
         chk("oor_bc", byte_count, v.exp_bc);
         chk("oor_cs", checksum, v.exp_cs);
      end else begin
         if (v.k == 1) begin mem_ack = 1'b1; mem_dout = v.dout; end
         @(negedge clk_sys);
         chk("rd_req", mem_req, 1'b1);
         chk("rd_wait", ioctl_wait, 1'b1);
         chk("rd_maddr", mem_addr, v.exp_maddr);
         for (int i = 2; i <= v.k; i++) begin
            @(posedge clk_sys); #1;
            if (i == v.k) begin mem_ack = 1'b1; mem_dout = v.dout; end
         end
         @(posedge clk_sys); #1 mem_ack = 1'b0;
         @(negedge clk_sys);
         chk("rd_req_drop", mem_req, 1'b0);
         chk("rd_wait_hold", ioctl_wait, 1'b1);
         @(posedge clk_sys);
         @(negedge clk_sys);
         chk("rd_wait_fall", ioctl_wait, 1'b0);
         chk("rd_din", ioctl_din, v.exp_din);
         chk("rd_bc", byte_count, v.exp_bc);
         chk("rd_cs", checksum, v.exp_cs);
         chk("rd_terr", timeout_err, v.exp_terr);
      end
   endtask

   initial begin
      int n;
      vec_t v;
      //         new   addr      dout   k  oor   maddr     din    bc     cs     terr
      vecs[0] = '{1'b1, 16'h0005, 8'h5A, 3, 1'b0, 16'hC005, 8'h5A, 16'd1, 8'h5A, 1'b0};
      vecs[1] = '{1'b1, 16'h0010, 8'hF0, 1, 1'b0, 16'hC010, 8'hF0, 16'd1, 8'hF0, 1'b0};
      vecs[2] = '{1'b0, 16'h0011, 8'h20, 2, 1'b0, 16'hC011, 8'h20, 16'd2, 8'h10, 1'b0};
      vecs[3] = '{1'b0, 16'h0012, 8'h01, 4, 1'b0, 16'hC012, 8'h01, 16'd3, 8'h11, 1'b0};
      vecs[4] = '{1'b0, 16'h8000, 8'h00, 0, 1'b1, 16'hC012, 8'hFF, 16'd3, 8'h11, 1'b0};
      vecs[5] = '{1'b0, 16'h7FFF, 8'h80, 1, 1'b0, 16'h3FFF, 8'h80, 16'd4, 8'h91, 1'b0};
      vecs[6] = '{1'b0, 16'hFFFF, 8'h00, 0, 1'b1, 16'h3FFF, 8'hFF, 16'd4, 8'h91, 1'b0};
      vecs[7] = '{1'b0, 16'h0001, 8'hFF, 2, 1'b0, 16'hC001, 8'hFF, 16'd5, 8'h90, 1'b0};

      reset = 1'b1; ioctl_upload = 1'b0; ioctl_rd = 1'b0; ioctl_addr = '0;
      mem_ack = 1'b0; mem_dout = '0;
      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      chk("rst_din", ioctl_din, 8'h00);
      chk("rst_wait", ioctl_wait, 1'b0);
      chk("rst_req", mem_req, 1'b0);
      chk("rst_maddr", mem_addr, 16'h0);
      chk("rst_bc", byte_count, 16'h0);
      chk("rst_cs", checksum, 8'h00);
      chk("rst_terr", timeout_err, 1'b0);
      chk("rst_done", done, 1'b0);
      @(posedge clk_sys); #1 reset = 1'b0;
      @(posedge clk_sys); #1 ioctl_upload = 1'b1;
      repeat (2) @(posedge clk_sys);

      // Reset while a fetch is in REQ, then a stray ack.
      @(posedge clk_sys); #1 ioctl_rd = 1'b1; ioctl_addr = 16'h0003;
      @(posedge clk_sys); #1 ioctl_rd = 1'b0;
      @(negedge clk_sys) chk("mid_req_pre", mem_req, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_req", mem_req, 1'b0);
      chk("mid_rst_wait", ioctl_wait, 1'b0);
      chk("mid_rst_maddr", mem_addr, 16'h0);
      chk("mid_rst_din", ioctl_din, 8'h00);
      @(posedge clk_sys); #1 reset = 1'b0;
      @(posedge clk_sys); #1 mem_ack = 1'b1; mem_dout = 8'hAA;
      @(posedge clk_sys); #1 mem_ack = 1'b0;
      @(negedge clk_sys);
      chk("stray_ack_din", ioctl_din, 8'h00);
      chk("stray_ack_req", mem_req, 1'b0);
      chk("stray_ack_bc", byte_count, 16'h0);

      for (int i = 0; i < 8; i++) begin
         if (vecs[i].new_sess) new_session();
         do_read(vecs[i]);
      end

      // Timeout: no ack ever arrives.
      new_session();
      @(posedge clk_sys); #1 ioctl_rd = 1'b1; ioctl_addr = 16'h0020;
      @(posedge clk_sys); #1 ioctl_rd = 1'b0;
      @(negedge clk_sys);
      n = 0;
      for (int i = 0; i < 400; i++) begin
         if (!mem_req) break;
         n++;
         @(negedge clk_sys);
      end
      chk("tmo_cycles", n, 255);
      chk("tmo_din", ioctl_din, 8'hFF);
      chk("tmo_err", timeout_err, 1'b1);
      @(negedge clk_sys);
      chk("tmo_wait", ioctl_wait, 1'b0);
      chk("tmo_bc", byte_count, 16'd1);
      chk("tmo_cs", checksum, 8'hFF);
      v = '{1'b0, 16'h0021, 8'h02, 1, 1'b0, 16'hC021, 8'h02, 16'd2, 8'h01, 1'b1};
      do_read(v);

      // Ack on the very cycle the timeout would fire.
      new_session();
      v = '{1'b0, 16'h0030, 8'h3C, 255, 1'b0, 16'hC030, 8'h3C, 16'd1, 8'h3C, 1'b0};
      do_read(v);

      // Session ends while the fetch is outstanding.
      @(posedge clk_sys); #1 ioctl_rd = 1'b1; ioctl_addr = 16'h0040;
      @(posedge clk_sys); #1 ioctl_rd = 1'b0; ioctl_upload = 1'b0;
      @(posedge clk_sys); #1 mem_ack = 1'b1; mem_dout = 8'h77;
      chk("end_done", done, 1'b1);
      chk("end_req_held", mem_req, 1'b1);
      @(posedge clk_sys); #1 mem_ack = 1'b0;
      @(negedge clk_sys);
      chk("end_done_clr", done, 1'b0);
      chk("end_req_drop", mem_req, 1'b0);
      chk("end_din", ioctl_din, 8'h77);
      @(negedge clk_sys);
      chk("end_wait", ioctl_wait, 1'b0);
      chk("end_bc", byte_count, 16'd1);
      chk("end_cs", checksum, 8'h3C);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
